error_recovery_ctrl: RTL

ERROR_RECOVERY_CTRL -- requirements
Module: error_recovery_ctrl

---
 rtl/error_recovery_pkg.sv | 26 ++
 rtl/err_sat_counter.sv | 27 ++
 rtl/error_recovery_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/error_recovery_pkg.sv
// Shared definitions for the pipeline error recovery controller:
// FSM state encoding, default parameters and a counter-width helper.
package error_recovery_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_RESTORE = 2'd2,
        ST_REPLAY  = 2'd3
    } rec_state_e;

    localparam int DEF_NUM_STAGES    = 4;
    localparam int DEF_REPLAY_CYCLES = 2;
    localparam int DEF_WINDOW        = 64;
    localparam int DEF_THRESH        = 4;

    // Bits needed to hold values 0..maxval (never less than one bit).
    function automatic int cnt_width(input int maxval);
        if (maxval < 2) begin
            return 1;
        end else begin
            return $clog2(maxval + 1);
        end
    endfunction

endpackage

// File: rtl/err_sat_counter.sv
// Saturating up-counter with a synchronous clear that can load the
// current increment, so a window restart can count its first event.
module err_sat_counter #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count register: clear/restart, else increment until MAX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= {WIDTH{1'b0}};
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : {WIDTH{1'b0}};
        end else if (inc && (count != MAX)) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/error_recovery_ctrl.sv
// Stall / restore / replay sequencer for timing-error recovery, with a
// saturating total error count and a windowed error-rate throttle request.
module error_recovery_ctrl
    import error_recovery_pkg::*;
#(
    parameter int NUM_STAGES    = DEF_NUM_STAGES,
    parameter int REPLAY_CYCLES = DEF_REPLAY_CYCLES,
    parameter int WINDOW        = DEF_WINDOW,
    parameter int THRESH        = DEF_THRESH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] error_in,
    output logic                  stall,
    output logic [NUM_STAGES-1:0] restore_sel,
    output logic                  replay,
    output logic                  busy,
    output logic [15:0]           err_count,
    output logic                  throttle_req
);

    localparam int RC_W = cnt_width(REPLAY_CYCLES - 1);
    localparam int WC_W = cnt_width(WINDOW - 1);
    localparam int TC_W = cnt_width(THRESH);

    rec_state_e            state_r, state_nxt_s;
    logic [NUM_STAGES-1:0] mask_r, mask_nxt_s;
    logic [NUM_STAGES-1:0] pending_r, pending_nxt_s;
    logic [NUM_STAGES-1:0] merged_s;
    logic [RC_W-1:0]       rcnt_r, rcnt_nxt_s;
    logic                  event_s;

    logic                  stall_nxt_s, replay_nxt_s, busy_nxt_s;
    logic [NUM_STAGES-1:0] rsel_nxt_s;

    logic [WC_W-1:0]       win_pos_r;
    logic                  wrap_s;
    logic [TC_W-1:0]       win_cnt_s;
    logic                  win_full_s;

    assign event_s  = |error_in;
    assign merged_s = pending_r | error_in;

    // FSM state, recovery masks and replay down-counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            mask_r    <= {NUM_STAGES{1'b0}};
            pending_r <= {NUM_STAGES{1'b0}};
            rcnt_r    <= {RC_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            mask_r    <= mask_nxt_s;
            pending_r <= pending_nxt_s;
            rcnt_r    <= rcnt_nxt_s;
        end
    end

    // Next-state logic; errors seen during recovery accumulate into pending
    always_comb begin
        state_nxt_s   = state_r;
        mask_nxt_s    = mask_r;
        pending_nxt_s = pending_r;
        rcnt_nxt_s    = rcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (event_s) begin
                    state_nxt_s = ST_STALL;
                    mask_nxt_s  = error_in;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STALL: begin
                state_nxt_s   = ST_RESTORE;
                pending_nxt_s = merged_s;
            end
            ST_RESTORE: begin
                state_nxt_s   = ST_REPLAY;
                pending_nxt_s = merged_s;
                rcnt_nxt_s    = RC_W'(REPLAY_CYCLES - 1);
            end
            ST_REPLAY: begin
                if (rcnt_r == {RC_W{1'b0}}) begin
                    // Exit decision includes an error arriving this very cycle
                    pending_nxt_s = {NUM_STAGES{1'b0}};
                    if (|merged_s) begin
                        state_nxt_s = ST_STALL;
                        mask_nxt_s  = merged_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        mask_nxt_s  = {NUM_STAGES{1'b0}};
                    end
                end else begin
                    rcnt_nxt_s    = rcnt_r - RC_W'(1);
                    pending_nxt_s = merged_s;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                mask_nxt_s    = {NUM_STAGES{1'b0}};
                pending_nxt_s = {NUM_STAGES{1'b0}};
                rcnt_nxt_s    = {RC_W{1'b0}};
            end
        endcase
    end

    // Output decode from the upcoming state so registered outputs track it
    always_comb begin
        stall_nxt_s  = 1'b0;
        replay_nxt_s = 1'b0;
        busy_nxt_s   = 1'b0;
        rsel_nxt_s   = {NUM_STAGES{1'b0}};
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_STALL: begin
                stall_nxt_s = 1'b1;
                busy_nxt_s  = 1'b1;
            end
            ST_RESTORE: begin
                stall_nxt_s = 1'b1;
                busy_nxt_s  = 1'b1;
                rsel_nxt_s  = mask_nxt_s;
            end
            ST_REPLAY: begin
                stall_nxt_s  = 1'b1;
                busy_nxt_s   = 1'b1;
                replay_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Recovery output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall       <= 1'b0;
            replay      <= 1'b0;
            busy        <= 1'b0;
            restore_sel <= {NUM_STAGES{1'b0}};
        end else begin
            stall       <= stall_nxt_s;
            replay      <= replay_nxt_s;
            busy        <= busy_nxt_s;
            restore_sel <= rsel_nxt_s;
        end
    end

    err_sat_counter #(
        .WIDTH (16),
        .MAX   (16'hFFFF)
    ) u_err_count (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (event_s),
        .count (err_count)
    );

    assign wrap_s = (win_pos_r == WC_W'(WINDOW - 1));

    // Free-running observation window position
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_pos_r <= {WC_W{1'b0}};
        end else if (wrap_s) begin
            win_pos_r <= {WC_W{1'b0}};
        end else begin
            win_pos_r <= win_pos_r + WC_W'(1);
        end
    end

    err_sat_counter #(
        .WIDTH (TC_W),
        .MAX   (TC_W'(THRESH))
    ) u_win_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (wrap_s),
        .inc   (event_s),
        .count (win_cnt_s)
    );

    assign win_full_s = (win_cnt_s == TC_W'(THRESH));

    // Throttle request: sticky in a window, re-evaluated at each wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            throttle_req <= 1'b0;
        end else if (wrap_s) begin
            throttle_req <= win_full_s;
        end else begin
            throttle_req <= throttle_req | win_full_s;
        end
    end

endmodule
